sum_block_accumulator: RTL and testbench
========================================

# sum_block_accumulator

Downstream consumer of the 16-bit registered adder stage. It takes the adder's 17-bit `sum` stream as valid-qualified beats and accumulates fixed-length blocks of `BLOCK_LEN` beats into a wide saturating total. It also tracks the block maximum and presents each completed block on a ready/valid output register. It sits between the adder pipeline and the result checker/readout logic.

## Interface
Parameters:
- `IN_W`, 17: width of incoming sum beats (adder sum incl. carry-out).
- `ACC_W`, 24: accumulator/output width; must be ≥ `IN_W`.
- `BLOCK_LEN`, 8: beats per block; legal range 2..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort of the current partial block.
- `in_valid`  in  1  `in_sum` holds a valid beat.
- `in_ready`  out  1  block can accept a beat this cycle.
- `in_sum`  in  `IN_W`  adder result, unsigned.
- `out_valid`  out  1  `out_acc`/`out_max`/`out_ovf` hold a completed block.
- `out_ready`  in  1  consumer accepts the output this cycle.
- `out_acc`  out  `ACC_W`  block total, saturated.
- `out_max`  out  `IN_W`  largest beat in the block.
- `out_ovf`  out  1  block total saturated.

## Operation
- Internal state:
  - `acc` (`ACC_W`), `max` (`IN_W`), `ovf` flag.
  - `cnt`, 8-bit beat counter, 0..`BLOCK_LEN`-1.
  - Output register set: `out_*` plus `out_valid`.
- Beat acceptance is `in_valid && in_ready`.
- On acceptance:
  - `in_sum` is zero-extended to `ACC_W + 1` bits and added to `acc`.
  - If the carry bit is set, or `ovf` is already set, the result is forced to all-ones and `ovf` is set.
  - `max` updates to `in_sum` if larger.
  - `cnt` increments.
- Last beat (`cnt == BLOCK_LEN-1` at acceptance):
  - The updated total, max and ovf load into the output registers and `out_valid` sets.
  - `acc`, `max`, `ovf` and `cnt` return to 0 on the same edge.
- Output handshake:
  - `out_valid && out_ready` clears `out_valid` at the edge, unless a new block loads on that same edge, in which case `out_valid` stays 1 with the new data.
  - Output data is stable while `out_valid && !out_ready`.
- `in_ready` is combinational: `reset && !clear && !(cnt == BLOCK_LEN-1 && out_valid && !out_ready)`.
  - A full output register stalls only the block-completing beat. Earlier beats of the next block continue to accumulate.
- `clear`:
  - Zeroes `acc`, `max`, `ovf` and `cnt`.
  - Forces `in_ready` low, so no beat is taken that cycle.
  - Leaves the output registers and `out_valid` untouched.
- `in_sum` is only sampled on acceptance; its value is a don't-care otherwise.

## Timing
- Reset (`reset` low, asynchronous):
  - Immediately: `out_valid`=0, `out_acc`=0, `out_max`=0, `out_ovf`=0, `in_ready`=0.
  - Internal `acc`, `max`, `ovf` and `cnt` are zeroed.
- First acceptance is possible at the first rising edge after `reset` deasserts.
- Throughput: one beat per cycle sustained when `out_ready`=1.
- Latency: last beat accepted at edge k gives `out_valid`=1 and new data visible after edge k.
- The upstream adder has one cycle of latency. The feeding logic delays operand-valid by one cycle to form `in_valid`; this block adds no alignment.
- Simultaneous events:
  - Last beat + `out_ready`=1 with `out_valid`=1: the old result is consumed and the new result loaded on the same edge, with no bubble.
  - `clear` + `in_valid`: the beat is not accepted.
  - `reset` mid-block: the partial block is lost and the output is dropped.
- No wrap-around: `cnt` never exceeds `BLOCK_LEN-1`.

## Test plan
- **Reset mid-block:** assert `reset` low after 3 accepted beats, between edges. Required: all outputs 0 without waiting for a clock edge. After release, a block of 8 × `0x00001` gives `out_acc`=`0x000008`.
- **Basic block:** beats `0x00001`..`0x00008` back-to-back, `out_ready`=1. Required: `out_valid` high the cycle after the 8th edge for exactly one cycle, with `out_acc`=`0x000024`, `out_max`=`0x00008`, `out_ovf`=0.
- **Backpressure:** `out_ready`=0, 16 beats of `0x1FFFE`. Required:
  - First block gives `out_acc`=`0x0FFFF0` and is held stable.
  - `in_ready` drops while the 16th beat is pending.
  - A one-cycle `out_ready` pulse loads the second block on that edge (`out_valid` stays 1, `out_acc`=`0x0FFFF0`).
- **Bubbles:** the beat sequence from the basic-block scenario with random `in_valid` gaps and `in_sum`=`0x1ABCD` during gaps. Required: identical output to the basic-block scenario.
- **Clear:** 3 beats of `0x00005`, then `clear` with `in_valid`=1, then 8 beats of `0x10000`. Required: `out_acc`=`0x080000`, `out_max`=`0x10000`, and the clear-cycle beat is not counted.
- **Saturation:** with `ACC_W`=18 and `BLOCK_LEN`=4, feed 4 beats of `0x1FFFF`. Required: `out_acc`=`0x3FFFF`, `out_ovf`=1, `out_max`=`0x1FFFF`. The next block of 4 × `0x00001` gives `out_acc`=`0x00004`, `out_ovf`=0.

Source files
------------

// File: rtl/sum_block_accumulator.sv
// sum_block_accumulator: accumulates fixed-length blocks of unsigned adder
// beats into a saturating total, tracks the block maximum and presents each
// completed block on a ready/valid output register.
module sum_block_accumulator #(
  parameter int IN_W      = 17,
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [IN_W-1:0]  out_max,
  output logic             out_ovf
);

  localparam logic [7:0] LAST = 8'(BLOCK_LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [IN_W-1:0]  blk_max;
  logic             ovf;
  logic [7:0]       cnt;

  logic [ACC_W:0]   sum_ext;
  logic             sat;
  logic [ACC_W-1:0] acc_next;
  logic [IN_W-1:0]  max_next;
  logic             last;
  logic             accept;

  // Carry out of the widened add, or a sticky overflow, pins the total at all-ones.
  assign sum_ext  = {1'b0, acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_sum};
  assign sat      = sum_ext[ACC_W] | ovf;
  assign acc_next = sat ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  assign max_next = (in_sum > blk_max) ? in_sum : blk_max;
  assign last     = (cnt == LAST);

  // Only the block-completing beat waits for the output register to free up.
  assign in_ready = reset && !clear && !(last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;

  // Running block state: cleared on abort, restarted after the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      blk_max <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
    end else if (clear) begin
      acc     <= '0;
      blk_max <= '0;
      ovf     <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      if (last) begin
        acc     <= '0;
        blk_max <= '0;
        ovf     <= 1'b0;
        cnt     <= '0;
      end else begin
        acc     <= acc_next;
        blk_max <= max_next;
        ovf     <= sat;
        cnt     <= cnt + 8'd1;
      end
    end
  end

  // Output register: a new block loads even while the old one is being consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_max   <= '0;
      out_ovf   <= 1'b0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      out_acc   <= acc_next;
      out_max   <= max_next;
      out_ovf   <= sat;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Scoreboard bench for sum_block_accumulator: default instance plus a narrow
// 18-bit / 4-beat instance for saturation.
module tb_sum_block_accumulator;

  typedef struct packed {
    logic [23:0] acc;
    logic [16:0] mx;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_sum = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_acc;
  logic [16:0] out_max;
  logic        out_ovf;

  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [16:0] s_in_sum = '0;
  logic        s_out_valid;
  logic [17:0] s_out_acc;
  logic [16:0] s_out_max;
  logic        s_out_ovf;

  int checks = 0;
  int fails  = 0;
  exp_t q[$];
  exp_t sq[$];

  always #5 clk = ~clk;

  sum_block_accumulator dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_max(out_max), .out_ovf(out_ovf)
  );

  sum_block_accumulator #(.IN_W(17), .ACC_W(18), .BLOCK_LEN(4)) dut_sat (
    .clk(clk), .reset(reset), .clear(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sum(s_in_sum),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_acc(s_out_acc), .out_max(s_out_max), .out_ovf(s_out_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: a handshake seen at the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 32'(out_acc), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_acc", 32'(out_acc), 32'(e.acc));
        chk("out_max", 32'(out_max), 32'(e.mx));
        chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    if (reset && s_out_valid) begin
      if (sq.size() == 0) chk("sat_unexpected_output", 32'(s_out_acc), 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = sq.pop_front();
        chk("sat_out_acc", 32'(s_out_acc), 32'(e.acc[17:0]));
        chk("sat_out_max", 32'(s_out_max), 32'(e.mx));
        chk("sat_out_ovf", 32'(s_out_ovf), 32'(e.ovf));
      end
    end
  end

  task automatic expect_blk(input logic [23:0] a, input logic [16:0] m, input logic o);
    exp_t e;
    e.acc = a; e.mx = m; e.ovf = o;
    q.push_back(e);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input logic [16:0] v);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_sum   = v;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sum   = 17'h1ABCD;
  endtask

  task automatic send_sat(input logic [16:0] v);
    s_in_valid = 1'b1;
    s_in_sum   = v;
    @(negedge clk);
    if (!s_in_ready) chk("sat_in_ready", 32'(s_in_ready), 32'd1);
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_acc", 32'(out_acc), 32'd0);
    idle(2);
    reset = 1'b1;

    // Basic block, back-to-back
    expect_blk(24'h000024, 17'h00008, 1'b0);
    for (int i = 1; i <= 8; i++) send(17'(i));
    chk("basic_valid_set", 32'(out_valid), 32'd1);
    idle(1);
    chk("basic_valid_one_cycle", 32'(out_valid), 32'd0);

    // Bubbles: same beats with idle gaps and junk in_sum
    expect_blk(24'h000024, 17'h00008, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      idle($urandom_range(0, 3));
      send(17'(i));
    end
    idle(2);

    // Clear drops the partial block and the beat offered during clear
    for (int i = 0; i < 3; i++) send(17'h00005);
    in_valid = 1'b1; in_sum = 17'h00005; clear = 1'b1;
    @(negedge clk);
    chk("clear_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    expect_blk(24'h080000, 17'h10000, 1'b0);
    for (int i = 0; i < 8; i++) send(17'h10000);
    idle(2);

    // Backpressure: two blocks against a stalled consumer
    out_ready = 1'b0;
    expect_blk(24'h0FFFF0, 17'h1FFFE, 1'b0);
    expect_blk(24'h0FFFF0, 17'h1FFFE, 1'b0);
    for (int i = 0; i < 8; i++) send(17'h1FFFE);
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 7; i++) send(17'h1FFFE);
    in_valid = 1'b1; in_sum = 17'h1FFFE;
    @(negedge clk);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_hold_acc", 32'(out_acc), 32'h0FFFF0);
    idle(3);
    @(negedge clk);
    chk("bp_still_stalled", 32'(in_ready), 32'd0);
    chk("bp_hold_max", 32'(out_max), 32'h1FFFE);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_pulse", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp_no_bubble_valid", 32'(out_valid), 32'd1);
    chk("bp_second_acc", 32'(out_acc), 32'h0FFFF0);
    idle(2);
    out_ready = 1'b1;
    idle(2);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Saturation on the narrow instance
    begin
      exp_t e;
      e.acc = 24'h03FFFF; e.mx = 17'h1FFFF; e.ovf = 1'b1; sq.push_back(e);
      e.acc = 24'h000004; e.mx = 17'h00001; e.ovf = 1'b0; sq.push_back(e);
    end
    for (int i = 0; i < 4; i++) send_sat(17'h1FFFF);
    for (int i = 0; i < 4; i++) send_sat(17'h00001);
    idle(3);

    // Reset mid-block with a result left pending
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(17'h00003);
    for (int i = 0; i < 3; i++) send(17'h00002);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_acc", 32'(out_acc), 32'd0);
    chk("rst_out_max", 32'(out_max), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    idle(2);
    reset = 1'b1;
    out_ready = 1'b1;
    expect_blk(24'h000008, 17'h00001, 1'b0);
    for (int i = 0; i < 8; i++) send(17'h00001);

    guard = 0;
    while ((q.size() != 0 || sq.size() != 0) && guard < 100) begin
      guard++;
      idle(1);
    end
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("sat_scoreboard_empty", 32'(sq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
